// File: rtl/or_pair_sequencer.sv
// Clocked scheduler that walks one shared 2-input OR over every unordered index pair (i,j), j>=i.
// Optional handshake ones counter enabled by defining OR_SEQ_ONES_CNT_EN.
module or_pair_sequencer #(
   parameter int N = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               start,
   input  logic [N-1:0]                       in_vec,
   output logic                               busy,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [$clog2(N)-1:0]               out_i,
   output logic [$clog2(N)-1:0]               out_j,
   output logic                               out_a,
   output logic                               out_b,
   output logic                               out_y,
`ifdef OR_SEQ_ONES_CNT_EN
   output logic [$clog2(N*(N+1)/2+1)-1:0]     ones_cnt,
`endif
   output logic                               done
);

   localparam int IW = $clog2(N);
   localparam int NP = N * (N + 1) / 2;
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t          r_state;
   logic [N-1:0]    r_snap;
   logic [IW-1:0]   r_i;
   logic [IW-1:0]   r_j;
   logic            r_valid;
   logic            r_busy;
   logic            r_done;
   logic            r_a;
   logic            r_b;
   logic            r_y;

   logic            w_hs;
   logic            w_last;
   logic [IW-1:0]   w_ni;
   logic [IW-1:0]   w_nj;

   assign w_hs   = r_valid & out_ready;
   assign w_last = (r_i == LAST) && (r_j == LAST);

   // Next pair: advance j along the row, else move to the diagonal of the next row.
   always_comb begin
      w_ni = r_i;
      w_nj = r_j;
      if (r_j != LAST) begin
         w_nj = r_j + IW'(1);
      end else begin
         w_ni = r_i + IW'(1);
         w_nj = r_i + IW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_snap  <= '0;
         r_i     <= '0;
         r_j     <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_a     <= 1'b0;
         r_b     <= 1'b0;
         r_y     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_snap  <= in_vec;
                  r_i     <= '0;
                  r_j     <= '0;
                  r_a     <= in_vec[0];
                  r_b     <= in_vec[0];
                  r_y     <= in_vec[0];
                  r_valid <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (w_hs) begin
                  if (w_last) begin
                     r_valid <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_i <= w_ni;
                     r_j <= w_nj;
                     r_a <= r_snap[w_ni];
                     r_b <= r_snap[w_nj];
                     r_y <= r_snap[w_ni] | r_snap[w_nj];
                  end
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef OR_SEQ_ONES_CNT_EN
   localparam int CW = $clog2(NP + 1);
   logic [CW-1:0] r_cnt;

   // Counts accepted results that were 1; holds after the sweep until the next start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if ((r_state == S_IDLE) && start) begin
         r_cnt <= '0;
      end else if (w_hs && r_y) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign ones_cnt = r_cnt;
`endif

   assign busy      = r_busy;
   assign out_valid = r_valid;
   assign out_i     = r_i;
   assign out_j     = r_j;
   assign out_a     = r_a;
   assign out_b     = r_b;
   assign out_y     = r_y;
   assign done      = r_done;

endmodule

// File: tb/tb_or_pair_sequencer.sv
// Randomized bench for or_pair_sequencer against a nested-loop pair model.
module tb_or_pair_sequencer;

   localparam int N  = 4;
   localparam int IW = 2;
   localparam int NP = 10;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [N-1:0]  in_vec;
   logic          busy;
   logic          out_valid;
   logic          out_ready;
   logic [IW-1:0] out_i;
   logic [IW-1:0] out_j;
   logic          out_a;
   logic          out_b;
   logic          out_y;
   logic          done;
`ifdef OR_SEQ_ONES_CNT_EN
   logic [3:0]    ones_cnt;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   or_pair_sequencer #(.N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_vec    (in_vec),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_i     (out_i),
      .out_j     (out_j),
      .out_a     (out_a),
      .out_b     (out_b),
      .out_y     (out_y),
`ifdef OR_SEQ_ONES_CNT_EN
      .ones_cnt  (ones_cnt),
`endif
      .done      (done)
   );

   // mode: 0 ready=1, 1 random, 2 toggle, 3 stall 3 cycles at pair index 2,
   //       4 ready=1 with start pulses at pair (1,2) and on the done cycle
   task automatic do_sweep(input logic [N-1:0] vec, input int mode, input string tag);
      logic [IW-1:0] ei[NP];
      logic [IW-1:0] ej[NP];
      int k, idx, ones, stall, cyc;
      logic ey, fin;
      k = 0;
      for (int a = 0; a < N; a++)
         for (int b = a; b < N; b++) begin
            ei[k] = IW'(a);
            ej[k] = IW'(b);
            k++;
         end
      @(negedge clk);
      in_vec    = vec;
      start     = 1'b1;
      out_ready = (mode == 1 || mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      idx = 0; ones = 0; stall = 0; fin = 1'b0;
      for (cyc = 0; cyc < 200 && !fin; cyc++) begin
         @(negedge clk);
         start  = 1'b0;
         in_vec = N'($urandom);
         if (idx < NP) begin
            ey = vec[ei[idx]] | vec[ej[idx]];
            n_checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 ||
                out_i !== ei[idx] || out_j !== ej[idx] ||
                out_a !== vec[ei[idx]] || out_b !== vec[ej[idx]] || out_y !== ey)
               $display("FAIL %s pair%0d: got v=%b busy=%b done=%b i=%0d j=%0d a=%b b=%b y=%b, want v=1 busy=1 done=0 i=%0d j=%0d a=%b b=%b y=%b",
                        tag, idx, out_valid, busy, done, out_i, out_j, out_a, out_b, out_y,
                        ei[idx], ej[idx], vec[ei[idx]], vec[ej[idx]], ey);
            else
               n_pass++;
            case (mode)
               0: out_ready = 1'b1;
               2: out_ready = ~out_ready;
               3: begin
                  if (idx == 2 && stall < 3) begin
                     out_ready = 1'b0;
                     stall++;
                  end else begin
                     out_ready = 1'b1;
                  end
               end
               4: begin
                  out_ready = 1'b1;
                  if (idx == 5) begin
                     start  = 1'b1;
                     in_vec = '1;
                  end
               end
               default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_ready) begin
               if (ey) ones++;
               idx++;
            end
         end else begin
            n_checks++;
            if (out_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b1)
               $display("FAIL %s done_cycle: got v=%b done=%b busy=%b, want v=0 done=1 busy=1",
                        tag, out_valid, done, busy);
            else
               n_pass++;
`ifdef OR_SEQ_ONES_CNT_EN
            n_checks++;
            if (ones_cnt !== 4'(ones))
               $display("FAIL %s ones_cnt: got %0d want %0d", tag, ones_cnt, ones);
            else
               n_pass++;
`endif
            if (mode == 4) begin
               start  = 1'b1;
               in_vec = '1;
            end
            fin = 1'b1;
         end
      end
      if (!fin) begin
         n_checks++;
         $display("FAIL %s timeout: got %0d handshakes want %0d", tag, idx, NP);
      end
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0)
         $display("FAIL %s after_done: got busy=%b v=%b done=%b, want 0 0 0", tag, busy, out_valid, done);
      else
         n_pass++;
`ifdef OR_SEQ_ONES_CNT_EN
      n_checks++;
      if (ones_cnt !== 4'(ones))
         $display("FAIL %s ones_hold: got %0d want %0d", tag, ones_cnt, ones);
      else
         n_pass++;
`endif
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; in_vec = '0; out_ready = 1'b0;
      #2;
      n_checks++;
      if ({busy, out_valid, done, out_i, out_j, out_a, out_b, out_y} !== '0)
         $display("FAIL reset_outputs: got busy=%b v=%b done=%b i=%0d j=%0d a=%b b=%b y=%b, want all 0",
                  busy, out_valid, done, out_i, out_j, out_a, out_b, out_y);
      else
         n_pass++;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL idle_ready%0d: got v=%b busy=%b done=%b, want 0 0 0", c, out_valid, busy, done);
         else
            n_pass++;
      end
   endtask

   task automatic test_zero();
      do_sweep(4'b0000, 0, "zero");
   endtask

   task automatic test_pattern();
      do_sweep(4'b1010, 0, "pattern");
   endtask

   task automatic test_stall();
      do_sweep(4'b1010, 3, "stall");
   endtask

   task automatic test_start_ignored();
      do_sweep(4'b1010, 4, "start_ignored");
   endtask

   task automatic test_reset_mid();
      logic hit;
      hit = 1'b0;
      @(negedge clk);
      in_vec = 4'b1010; start = 1'b1; out_ready = 1'b1;
      for (int c = 0; c < 30 && !hit; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (out_valid === 1'b1 && out_i === 2'd2 && out_j === 2'd2) hit = 1'b1;
      end
      n_checks++;
      if (!hit)
         $display("FAIL reset_mid_reach: got i=%0d j=%0d want i=2 j=2", out_i, out_j);
      else
         n_pass++;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_i !== '0 || out_j !== '0)
         $display("FAIL reset_mid_abort: got v=%b busy=%b done=%b i=%0d j=%0d, want all 0",
                  out_valid, busy, done, out_i, out_j);
      else
         n_pass++;
`ifdef OR_SEQ_ONES_CNT_EN
      n_checks++;
      if (ones_cnt !== 4'd0)
         $display("FAIL reset_mid_cnt: got %0d want 0", ones_cnt);
      else
         n_pass++;
`endif
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0)
         $display("FAIL reset_mid_nodone: got done=%b want 0", done);
      else
         n_pass++;
      rst_n = 1'b1;
      do_sweep(N'($urandom), 0, "after_reset");
   endtask

   task automatic test_toggle();
      do_sweep(4'b1111, 2, "toggle");
   endtask

   task automatic test_random();
      for (int s = 0; s < 8; s++)
         do_sweep(N'($urandom), 1, $sformatf("random%0d", s));
   endtask

   initial begin
      test_reset();
      test_zero();
      test_pattern();
      test_stall();
      test_start_ignored();
      test_reset_mid();
      test_toggle();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
